// File: rtl/rr_tri_bus_arb.sv
// Packet-locked round-robin owner of a shared tri-state bus.
// Define XZ_SCRUB_EN to drive X/Z data bits onto the bus as 0.
module rr_tri_bus_arb #(
  parameter int NCH     = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   last,
  input  logic [W-1:0]     data [NCH],
  output logic [NCH-1:0]   gnt,
  output tri   [W-1:0]     bus,
  output logic             bus_vld,
  output logic             tmo,
  output logic [CNT_W-1:0] xz_cnt,
  output logic             xz_seen
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW = 8;

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [NCH-1:0]   gnt_q, gnt_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] xz_cnt_q, xz_cnt_d;
  logic             xz_seen_q, xz_seen_d;

  logic [W-1:0]     own_data;
  logic [W-1:0]     drv;
  logic             own_req;
  logic             own_last;
  logic             accept;
  logic             xz_beat;
  logic             rel;
  logic             stall_hit;
  logic [IW-1:0]    nxt_ptr;
  logic [IW-1:0]    arb_base;
  logic [NCH-1:0]   arb_excl;
  logic [NCH-1:0]   cand;
  logic [IW-1:0]    win_idx;
  logic             win_any;
  int               scan;

  assign own_req  = req[owner_q];
  assign own_last = last[owner_q];
  assign own_data = data[owner_q];
  assign accept   = gnt_q[owner_q] & own_req;
  assign xz_beat  = ((^own_data) === 1'bx);

  assign nxt_ptr = (int'(owner_q) == NCH - 1) ? '0
                 : owner_q + 1'b1;

  // While owning, the next winner is searched from owner+1
  // with the releasing channel masked out (unless it is alone).
  assign arb_base = (state_q == OWN) ? nxt_ptr : ptr_q;
  assign arb_excl = (state_q == OWN && NCH > 1)
                  ? (NCH'(1) << owner_q) : '0;
  assign cand     = req & ~arb_excl;

  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    scan    = 0;
    for (int i = 0; i < NCH; i++) begin
      scan = (int'(arb_base) + i) % NCH;
      if (!win_any && cand[IW'(scan)]) begin
        win_any = 1'b1;
        win_idx = IW'(scan);
      end
    end
  end

  assign stall_hit = !accept &&
                     (stall_q == SW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    stall_d   = stall_q;
    tmo_d     = 1'b0;
    xz_cnt_d  = xz_cnt_q;
    xz_seen_d = xz_seen_q;
    rel       = 1'b0;

    if (accept && xz_beat) begin
      xz_seen_d = 1'b1;
      if (xz_cnt_q != '1) begin
        xz_cnt_d = xz_cnt_q + 1'b1;
      end
    end

    unique case (1'b1)
      (state_q == IDLE): begin
        stall_d = '0;
        if (win_any) begin
          owner_d = win_idx;
          gnt_d   = NCH'(1) << win_idx;
          state_d = OWN;
        end
      end
      (state_q == OWN): begin
        stall_d = accept ? '0 : stall_q + 1'b1;
        rel     = (accept && own_last) || stall_hit;
        if (rel) begin
          tmo_d   = stall_hit;
          stall_d = '0;
          ptr_d   = nxt_ptr;
          if (win_any) begin
            owner_d = win_idx;
            gnt_d   = NCH'(1) << win_idx;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      stall_q   <= '0;
      tmo_q     <= 1'b0;
      xz_cnt_q  <= '0;
      xz_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      stall_q   <= stall_d;
      tmo_q     <= tmo_d;
      xz_cnt_q  <= xz_cnt_d;
      xz_seen_q <= xz_seen_d;
    end
  end

`ifdef XZ_SCRUB_EN
  always_comb begin
    drv = '0;
    for (int b = 0; b < W; b++) begin
      drv[b] = (own_data[b] === 1'b1);
    end
  end
`else
  assign drv = own_data;
`endif

  assign bus     = bus_vld ? drv : {W{1'bz}};
  assign bus_vld = accept;
  assign gnt     = gnt_q;
  assign tmo     = tmo_q;
  assign xz_cnt  = xz_cnt_q;
  assign xz_seen = xz_seen_q;

endmodule

// File: tb/tb_rr_tri_bus_arb.sv
// Directed bench for rr_tri_bus_arb: vector table plus
// hand sequences for timeout, X/Z counting and async reset.
module tb_rr_tri_bus_arb;

  localparam int NCH     = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 2;

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] gnt;
    logic       vld;
    logic       tmo;
    int         own;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NCH-1:0]   req = '0;
  logic [NCH-1:0]   last = '0;
  logic [W-1:0]     data_v [NCH];
  logic [NCH-1:0]   gnt;
  wire  [W-1:0]     bus;
  logic             bus_vld;
  logic             tmo;
  logic [CNT_W-1:0] xz_cnt;
  logic             xz_seen;

  int   n_vec = 0;
  int   n_bad = 0;
  logic four_state;
  logic [W-1:0] xdat;
  vec_t tab [12];

  always #5 clk = ~clk;

  rr_tri_bus_arb #(
    .NCH(NCH), .W(W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .last(last),
    .data(data_v), .gnt(gnt), .bus(bus),
    .bus_vld(bus_vld), .tmo(tmo),
    .xz_cnt(xz_cnt), .xz_seen(xz_seen)
  );

  task automatic cmp(string tag, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic chk_bus(string tag, logic ev, int own);
    logic [W-1:0] e;
    if (ev) begin
      e = data_v[own];
`ifdef XZ_SCRUB_EN
      for (int b = 0; b < W; b++) e[b] = (data_v[own][b] === 1'b1);
`endif
    end else begin
      e = {W{1'bz}};
    end
    if (ev || four_state) begin
      n_vec++;
      if (bus !== e) begin
        n_bad++;
        $display("FAIL %s.bus: got %b want %b", tag, bus, e);
      end
    end
  endtask

  task automatic chk(string tag, logic [3:0] eg, logic ev,
                     logic et, int own);
    cmp({tag, ".gnt"}, 32'(gnt), 32'(eg));
    cmp({tag, ".vld"}, 32'(bus_vld), 32'(ev));
    cmp({tag, ".tmo"}, 32'(tmo), 32'(et));
    chk_bus(tag, ev, own);
  endtask

  task automatic drive(logic [3:0] r, logic [3:0] l);
    @(negedge clk);
    req  = r;
    last = l;
    #1;
  endtask

  initial begin
    data_v[0] = 8'hA0;
    data_v[1] = 8'hB1;
    data_v[2] = 8'hC2;
    data_v[3] = 8'hD3;
    xdat = 8'b0000_x001;
    four_state = ((^xdat) === 1'bx);

    tab[0]  = '{4'b1010, 4'b1010, 4'b0000, 1'b0, 1'b0, -1};
    tab[1]  = '{4'b1010, 4'b1010, 4'b0010, 1'b1, 1'b0, 1};
    tab[2]  = '{4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b0, 3};
    tab[3]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, -1};
    tab[4]  = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, -1};
    tab[5]  = '{4'b1111, 4'b1111, 4'b0001, 1'b1, 1'b0, 0};
    tab[6]  = '{4'b1111, 4'b1111, 4'b0010, 1'b1, 1'b0, 1};
    tab[7]  = '{4'b1111, 4'b1111, 4'b0100, 1'b1, 1'b0, 2};
    tab[8]  = '{4'b1111, 4'b1111, 4'b1000, 1'b1, 1'b0, 3};
    tab[9]  = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 0};
    tab[10] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, -1};
    tab[11] = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, -1};

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset", 4'b0000, 1'b0, 1'b0, -1);
    cmp("reset.xz_cnt", 32'(xz_cnt), 32'd0);
    cmp("reset.xz_seen", 32'(xz_seen), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(tab[i].req, tab[i].last);
      chk($sformatf("tab%0d", i), tab[i].gnt, tab[i].vld,
          tab[i].tmo, tab[i].own);
    end

    for (int k = 1; k <= TIMEOUT; k++) begin
      drive(4'b1000, 4'b0000);
      chk($sformatf("stall%0d", k), 4'b0100, 1'b0, 1'b0, -1);
    end
    drive(4'b1000, 4'b1000);
    chk("tmo_rel", 4'b1000, 1'b1, 1'b1, 3);
    drive(4'b0000, 4'b0000);
    chk("tmo_after", 4'b0000, 1'b0, 1'b0, -1);

    drive(4'b0001, 4'b0000);
    chk("hold_req", 4'b0000, 1'b0, 1'b0, -1);
    for (int k = 0; k < 100; k++) begin
      drive(4'b0011, 4'b0000);
      chk($sformatf("hold%0d", k), 4'b0001, 1'b1, 1'b0, 0);
    end
    drive(4'b0011, 4'b0001);
    chk("hold_last", 4'b0001, 1'b1, 1'b0, 0);
    drive(4'b0010, 4'b0010);
    chk("hold_next", 4'b0010, 1'b1, 1'b0, 1);
    drive(4'b0000, 4'b0000);
    chk("hold_idle", 4'b0000, 1'b0, 1'b0, -1);

    data_v[0] = xdat;
    drive(4'b0001, 4'b0000);
    chk("xz_req", 4'b0000, 1'b0, 1'b0, -1);
    cmp("xz_req.cnt", 32'(xz_cnt), 32'd0);
    for (int b = 0; b < 4; b++) begin
      drive(4'b0001, (b == 3) ? 4'b0001 : 4'b0000);
      chk($sformatf("xz%0d", b), 4'b0001, 1'b1, 1'b0, 0);
      cmp($sformatf("xz%0d.cnt", b), 32'(xz_cnt),
          four_state ? b : 0);
    end
    drive(4'b0000, 4'b0000);
    chk("xz_end", 4'b0000, 1'b0, 1'b0, -1);
    cmp("xz_end.cnt", 32'(xz_cnt), four_state ? 32'd3 : 32'd0);
    cmp("xz_end.seen", 32'(xz_seen), four_state ? 32'd1 : 32'd0);
    data_v[0] = 8'hA0;

    drive(4'b0001, 4'b0000);
    chk("rst_req", 4'b0000, 1'b0, 1'b0, -1);
    drive(4'b0001, 4'b0000);
    chk("rst_pkt", 4'b0001, 1'b1, 1'b0, 0);
    #2;
    rst = 1'b1;
    req = 4'b0000;
    #1;
    chk("rst_mid", 4'b0000, 1'b0, 1'b0, -1);
    cmp("rst_mid.cnt", 32'(xz_cnt), 32'd0);
    cmp("rst_mid.seen", 32'(xz_seen), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    drive(4'b1001, 4'b1001);
    chk("rst_idle", 4'b0000, 1'b0, 1'b0, -1);
    drive(4'b1001, 4'b1001);
    chk("rst_ptr0", 4'b0001, 1'b1, 1'b0, 0);
    drive(4'b1000, 4'b1000);
    chk("rst_ch3", 4'b1000, 1'b1, 1'b0, 3);
    drive(4'b0000, 4'b0000);
    chk("rst_done", 4'b0000, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
